// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the external SRAM arbiter/controller.
package sram_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Strobe-length counter holds WAIT_STATES (0..15)
  localparam int WAIT_CNT_W = 4;

  // Index width that stays at least one bit for a single channel
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed priority
// with channel 0 highest. Grant is combinational; the pointer advances
// past the winner when an update is requested.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int IDX_W   = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic              upd,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  // Pick the winner and compute the pointer that follows it
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    ptr_d   = ptr_q;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          found   = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end else begin
      // Channels at or above the pointer first, then the wrapped-around ones
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i] && (i >= int'(ptr_q))) begin
          found   = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i] && (i < int'(ptr_q))) begin
          found   = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = en && found && (gnt_idx == IDX_W'(i));
    end
    if (upd && found) begin
      ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arbiter_controller.sv
// Multi-channel controller for one asynchronous SRAM with a shared data
// bus. Each granted access runs SETUP -> STROBE (WAIT_STATES+1) -> RECOVER.
module sram_arbiter_controller
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        reqValid,
  input  logic [NUM_CH-1:0]        reqWrite,
  input  logic [NUM_CH*ADDR_W-1:0] reqAddr,
  input  logic [NUM_CH*DATA_W-1:0] reqWdata,
  output logic [NUM_CH-1:0]        reqReady,
  output logic [NUM_CH-1:0]        rspValid,
  output logic [DATA_W-1:0]        rspRdata,
  inout  wire  [DATA_W-1:0]        memDataBus,
  output logic [ADDR_W-1:0]        memAddrBus,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     memEnable
);

  localparam int IDX_W = idx_width(NUM_CH);

  logic [1:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [IDX_W-1:0]      ch_q, ch_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  arb_en;
  logic [NUM_CH-1:0]     arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_write;
  logic                  drive_en;

  // Grants are only offered from IDLE and never while reset is held
  assign arb_en = (state_q == ST_IDLE) && !rst;

  sram_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (reqValid),
    .en     (arb_en),
    .upd    (arb_en),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx)
  );

  // Select the winning channel's request fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = reqAddr[i*ADDR_W +: ADDR_W];
        sel_wdata = reqWdata[i*DATA_W +: DATA_W];
        sel_write = reqWrite[i];
      end
    end
  end

  // FSM state, strobe counter and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Transaction latches; only observed outside IDLE, so no reset needed
  always_ff @(posedge clk) begin
    ch_q    <= ch_d;
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Next-state, counter, latch capture and read sampling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ch_d    = ch_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d = ST_SETUP;
          ch_d    = arb_idx;
          write_d = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = WAIT_CNT_W'(WAIT_STATES);
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          if (!write_q) rdata_d = memDataBus;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pin and handshake outputs decoded from the current state
  always_comb begin
    reqReady   = arb_gnt;
    rspRdata   = rdata_q;
    memEnable  = (state_q == ST_IDLE);
    memRead    = !((state_q == ST_STROBE) && !write_q);
    memWrite   = !((state_q == ST_STROBE) && write_q);
    memAddrBus = (state_q == ST_IDLE) ? '0 : addr_q;
    drive_en   = write_q && (state_q != ST_IDLE);
    for (int i = 0; i < NUM_CH; i++) begin
      rspValid[i] = (state_q == ST_RECOVER) && (ch_q == IDX_W'(i));
    end
  end

  // Write driver spans SETUP..RECOVER; a read never drives the bus
  assign memDataBus = drive_en ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter_controller.sv
// Directed bench for sram_arbiter_controller using three configurations:
// A: 2 ch, 1 wait state, round-robin; B: 4 ch, round-robin;
// C: 4 ch, 0 wait states, fixed priority.
module tb_sram_arbiter_controller;

  localparam logic [15:0] PARK = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic [1:0]  vld_a = '0, wr_a = '0;
  logic [35:0] addr_a = '0;
  logic [31:0] wd_a = '0;
  logic [1:0]  rdy_a, rsp_a;
  logic [15:0] rd_a;
  wire  [15:0] bus_a;
  logic [17:0] ma_a;
  logic        oe_a, we_a, ce_a;
  logic [15:0] mem_a [16];

  sram_arbiter_controller #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16),
                            .WAIT_STATES(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .reqValid(vld_a), .reqWrite(wr_a), .reqAddr(addr_a),
    .reqWdata(wd_a), .reqReady(rdy_a), .rspValid(rsp_a), .rspRdata(rd_a),
    .memDataBus(bus_a), .memAddrBus(ma_a), .memRead(oe_a), .memWrite(we_a),
    .memEnable(ce_a));

  // SRAM model A plus a parking driver while the chip is deselected
  assign bus_a = ce_a ? PARK : (!oe_a ? mem_a[ma_a[3:0]] : 16'hzzzz);
  always @(posedge clk) begin
    if (rst) mem_a[3] <= 16'hBEEF;
    else if (!ce_a && !we_a) mem_a[ma_a[3:0]] <= bus_a;
  end

  // ---------------- instance B ----------------
  logic [3:0]  vld_b = '0, wr_b = '0;
  logic [71:0] addr_b = '0;
  logic [63:0] wd_b = '0;
  logic [3:0]  rdy_b, rsp_b;
  logic [15:0] rd_b;
  wire  [15:0] bus_b;
  logic [17:0] ma_b;
  logic        oe_b, we_b, ce_b;

  sram_arbiter_controller #(.NUM_CH(4), .ADDR_W(18), .DATA_W(16),
                            .WAIT_STATES(1), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .reqValid(vld_b), .reqWrite(wr_b), .reqAddr(addr_b),
    .reqWdata(wd_b), .reqReady(rdy_b), .rspValid(rsp_b), .rspRdata(rd_b),
    .memDataBus(bus_b), .memAddrBus(ma_b), .memRead(oe_b), .memWrite(we_b),
    .memEnable(ce_b));

  assign bus_b = ce_b ? PARK : 16'hzzzz;

  // ---------------- instance C ----------------
  logic [3:0]  vld_c = '0, wr_c = '0;
  logic [71:0] addr_c = '0;
  logic [63:0] wd_c = '0;
  logic [3:0]  rdy_c, rsp_c;
  logic [15:0] rd_c;
  wire  [15:0] bus_c;
  logic [17:0] ma_c;
  logic        oe_c, we_c, ce_c;
  logic [15:0] mem_c [16];

  sram_arbiter_controller #(.NUM_CH(4), .ADDR_W(18), .DATA_W(16),
                            .WAIT_STATES(0), .ARB_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .reqValid(vld_c), .reqWrite(wr_c), .reqAddr(addr_c),
    .reqWdata(wd_c), .reqReady(rdy_c), .rspValid(rsp_c), .rspRdata(rd_c),
    .memDataBus(bus_c), .memAddrBus(ma_c), .memRead(oe_c), .memWrite(we_c),
    .memEnable(ce_c));

  assign bus_c = ce_c ? PARK : (!oe_c ? mem_c[ma_c[3:0]] : 16'hzzzz);
  always @(posedge clk) begin
    if (!rst && !ce_c && !we_c) mem_c[ma_c[3:0]] <= bus_c;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the falling edge of the next cycle
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;

    // Reset state
    cyc(); cyc();
    check("rst_rdy", rdy_a, 2'b00);
    check("rst_rsp", rsp_a, 2'b00);
    check("rst_rdata", rd_a, 16'h0000);
    check("rst_addr", ma_a, 18'h0);
    check("rst_pins", {oe_a, we_a, ce_a}, 3'b111);
    check("rst_bus", bus_a, PARK);
    cyc(); rst = 1'b0;

    // 1: single read, WAIT_STATES=1
    cyc(); vld_a = 2'b01; wr_a = 2'b00; addr_a[17:0] = 18'h00123; #1;
    check("t1_rdy_c0", rdy_a, 2'b01);
    check("t1_ce_c0", ce_a, 1'b1);
    cyc(); vld_a = 2'b00; #1;
    check("t1_ce_setup", ce_a, 1'b0);
    check("t1_addr_setup", ma_a, 18'h00123);
    check("t1_oe_setup", oe_a, 1'b1);
    cyc(); #1;
    check("t1_oe_c2", oe_a, 1'b0);
    check("t1_bus_c2", bus_a, 16'hBEEF);
    cyc(); #1;
    check("t1_oe_c3", oe_a, 1'b0);
    cyc(); #1;
    check("t1_oe_c4", oe_a, 1'b1);
    check("t1_rsp_c4", rsp_a, 2'b01);
    check("t1_rdata_c4", rd_a, 16'hBEEF);
    cyc(); #1;
    check("t1_rsp_c5", rsp_a, 2'b00);
    check("t1_ce_c5", ce_a, 1'b1);

    // 2: single write from channel 1
    cyc(); vld_a = 2'b10; wr_a = 2'b10; addr_a[35:18] = 18'h3FFFF; wd_a[31:16] = 16'h1234; #1;
    check("t2_rdy_c0", rdy_a, 2'b10);
    cyc(); vld_a = 2'b00; #1;
    check("t2_bus_setup", bus_a, 16'h1234);
    check("t2_we_setup", we_a, 1'b1);
    check("t2_ce_setup", ce_a, 1'b0);
    cyc(); #1;
    check("t2_we_c2", we_a, 1'b0);
    check("t2_bus_c2", bus_a, 16'h1234);
    cyc(); #1;
    check("t2_we_c3", we_a, 1'b0);
    cyc(); #1;
    check("t2_we_c4", we_a, 1'b1);
    check("t2_rsp_c4", rsp_a, 2'b10);
    check("t2_bus_c4", bus_a, 16'h1234);
    check("t2_rdata_kept", rd_a, 16'hBEEF);
    cyc(); #1;
    check("t2_bus_released", bus_a, PARK);
    check("t2_mem", mem_a[15], 16'h1234);

    // 5: reset during a write's strobe
    cyc(); vld_a = 2'b01; wr_a = 2'b01; addr_a[17:0] = 18'h00005; wd_a[15:0] = 16'h7777; #1;
    check("t5_rdy", rdy_a, 2'b01);
    cyc(); vld_a = 2'b00; #1;
    cyc(); #1;
    check("t5_we_strobe", we_a, 1'b0);
    rst = 1'b1; #1;
    check("t5_pins_rst", {oe_a, we_a, ce_a}, 3'b111);
    check("t5_bus_rst", bus_a, PARK);
    check("t5_addr_rst", ma_a, 18'h0);
    check("t5_rsp_rst", rsp_a, 2'b00);
    cyc(); #1;
    check("t5_rsp_hold", rsp_a, 2'b00);
    cyc(); rst = 1'b0; #1;
    check("t5_rsp_rel", rsp_a, 2'b00);
    cyc(); vld_a = 2'b11; wr_a = 2'b00; addr_a = {18'h3FFFF, 18'h00123}; #1;
    check("t5_ptr0", rdy_a, 2'b01);
    cyc(); vld_a = 2'b00; #1;
    cyc(); cyc(); cyc(); #1;
    check("t5_rsp", rsp_a, 2'b01);
    check("t5_rdata", rd_a, 16'hBEEF);

    // 3: round-robin fairness, all four channels requesting
    for (int c = 0; c <= 20; c++) begin
      cyc();
      if (c == 0) begin
        vld_b = 4'hF; wr_b = 4'hF; wd_b = 64'h4444_3333_2222_1111;
      end
      #1;
      e = (c % 5 == 0) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
      check($sformatf("t3_rdy_c%0d", c), rdy_b, e);
    end
    cyc(); vld_b = 4'h0;
    for (int k = 0; k < 5; k++) cyc();

    // 4: fixed priority, channels 2 and 3, zero wait states
    for (int c = 0; c <= 12; c++) begin
      cyc();
      if (c == 0) begin vld_c = 4'b1100; wr_c = 4'b1100; end
      if (c == 9) vld_c = 4'b1000;
      #1;
      e = (c == 12) ? 4'b1000 : ((c % 4 == 0) ? 4'b0100 : 4'b0000);
      check($sformatf("t4_rdy_c%0d", c), rdy_c, e);
    end
    cyc(); vld_c = 4'b0000;
    for (int k = 0; k < 5; k++) cyc();

    // 6: zero wait states, write then read back
    cyc(); vld_c = 4'b0001; wr_c = 4'b0001; addr_c[17:0] = 18'h00010; wd_c[15:0] = 16'hA5A5; #1;
    check("t6_wrdy", rdy_c, 4'b0001);
    cyc(); vld_c = 4'b0000; #1;
    check("t6_wbus_setup", bus_c, 16'hA5A5);
    check("t6_we_setup", we_c, 1'b1);
    cyc(); #1;
    check("t6_we_strobe", we_c, 1'b0);
    check("t6_wbus_strobe", bus_c, 16'hA5A5);
    cyc(); #1;
    check("t6_we_recover", we_c, 1'b1);
    check("t6_wrsp", rsp_c, 4'b0001);
    cyc(); vld_c = 4'b0010; wr_c = 4'b0000; addr_c[35:18] = 18'h00010; #1;
    check("t6_rrdy", rdy_c, 4'b0010);
    check("t6_bus_idle", bus_c, PARK);
    cyc(); vld_c = 4'b0000; #1;
    check("t6_oe_setup", oe_c, 1'b1);
    cyc(); #1;
    check("t6_oe_strobe", oe_c, 1'b0);
    check("t6_rbus_strobe", bus_c, 16'hA5A5);
    cyc(); #1;
    check("t6_oe_recover", oe_c, 1'b1);
    check("t6_rrsp", rsp_c, 4'b0010);
    check("t6_rdata", rd_c, 16'hA5A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
